// File: rtl/arcade_nvram_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arcade_nvram_pkg
// Description : Shared types and constants for the CMOS NVRAM upload path.
// Revision    : 1.0 - initial release
// ============================================================================
package arcade_nvram_pkg;

  // Read-back sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    LAT  = 2'd2,
    DONE = 2'd3
  } nv_state_t;

  // ioctl_index that selects the CMOS NVRAM transfer
  localparam logic [15:0] NV_INDEX_DEFAULT = 16'd4;

  // Byte returned for addresses beyond the CMOS RAM
  localparam logic [7:0]  NV_OOR_BYTE      = 8'hFF;

endpackage : arcade_nvram_pkg
`default_nettype wire

// File: rtl/cmos_nvram_uploader.sv
`default_nettype none
// ============================================================================
// Module      : cmos_nvram_uploader
// Description : Serves HPS ioctl upload reads of the Williams CMOS RAM one
//               byte at a time through a spare read port, yielding to the
//               core whenever it owns the port, and tracks whether the CMOS
//               has been written since the last completed save.
// Revision    : 1.0 - initial release
// ============================================================================
module cmos_nvram_uploader
  import arcade_nvram_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 4,                 // 1..8
  parameter logic [15:0] NV_INDEX = NV_INDEX_DEFAULT,
  parameter int          RAM_LAT  = 1                  // 1..4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              core_busy,
  input  logic              cpu_we,
  output logic              nvram_dirty,
  output logic              upload_active
);

  // Number of CMOS locations; the range check uses the full 25-bit address
  localparam logic [24:0] DEPTH    = 25'(1) << ADDR_W;
  // Latency counter holds remaining cycles minus one so RAM_LAT=4 fits 2 bits
  localparam logic [1:0]  LAT_INIT = 2'(RAM_LAT - 1);

  nv_state_t   state;
  nv_state_t   state_nxt;
  logic [1:0]  lat_cnt;
  logic        read_done;

  logic        matched;
  logic        in_range;
  logic        accepted;
  logic        upload_fall;

  logic        load_addr;
  logic        load_cnt;
  logic        dec_cnt;
  logic        cap_ram;
  logic        cap_oor;
  logic        complete;

  assign matched     = ioctl_upload && (ioctl_index == NV_INDEX);
  assign in_range    = (ioctl_addr < DEPTH);
  // Qualified by reset_n so nothing leaks onto ioctl_wait while in reset
  assign accepted    = reset_n && ioctl_rd && matched && (state == IDLE);
  assign upload_fall = upload_active && !matched;
  assign ioctl_wait  = accepted || (state != IDLE);

  // Sequencer state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the RAM strobe and datapath enables
  always_comb begin
    state_nxt = state;
    ram_rd    = 1'b0;
    load_addr = 1'b0;
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    cap_ram   = 1'b0;
    cap_oor   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (accepted) begin
          if (in_range) begin
            load_addr = 1'b1;
            state_nxt = SLOT;
          end else begin
            cap_oor   = 1'b1;
            complete  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SLOT: begin
        if (!matched) begin
          state_nxt = IDLE;
        end else if (!core_busy) begin
          ram_rd    = 1'b1;
          load_cnt  = 1'b1;
          state_nxt = LAT;
        end
      end
      LAT: begin
        // An abort wins over a capture so a late ram_dout is dropped
        if (!matched) begin
          state_nxt = IDLE;
        end else if (lat_cnt == 2'd0) begin
          cap_ram   = 1'b1;
          complete  = 1'b1;
          state_nxt = DONE;
        end else begin
          dec_cnt   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latched CMOS address and latency countdown
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
      lat_cnt  <= 2'd0;
    end else begin
      if (load_addr) begin
        ram_addr <= ioctl_addr[ADDR_W-1:0];
      end
      if (load_cnt) begin
        lat_cnt <= LAT_INIT;
      end else if (dec_cnt) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  // Byte returned to the HPS; holds across aborts and ignored reads
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_din <= 8'h00;
    end else if (cap_oor) begin
      ioctl_din <= NV_OOR_BYTE;
    end else if (cap_ram) begin
      ioctl_din <= 8'(ram_dout);
    end
  end

  // Upload tracking and dirty flag; a core write beats a same-cycle clear
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      upload_active <= 1'b0;
      read_done     <= 1'b0;
      nvram_dirty   <= 1'b0;
    end else begin
      upload_active <= matched;
      if (upload_fall) begin
        read_done <= 1'b0;
      end else if (complete) begin
        read_done <= 1'b1;
      end
      if (cpu_we) begin
        nvram_dirty <= 1'b1;
      end else if (upload_fall && read_done) begin
        nvram_dirty <= 1'b0;
      end
    end
  end

endmodule : cmos_nvram_uploader
`default_nettype wire

// File: tb/tb_cmos_nvram_uploader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmos_nvram_uploader
// Description : Self-checking bench for cmos_nvram_uploader with a behavioural
//               CMOS RAM and a transaction-level timing/dirty model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_nvram_uploader;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 4;
  localparam int RAM_LAT = 1;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk_sys;
  logic              reset_n;
  logic              ioctl_upload;
  logic [15:0]       ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_dout;
  logic              core_busy;
  logic              cpu_we;
  logic              nvram_dirty;
  logic              upload_active;

  cmos_nvram_uploader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NV_INDEX (16'd4),
    .RAM_LAT  (RAM_LAT)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_upload  (ioctl_upload),
    .ioctl_index   (ioctl_index),
    .ioctl_rd      (ioctl_rd),
    .ioctl_addr    (ioctl_addr),
    .ioctl_din     (ioctl_din),
    .ioctl_wait    (ioctl_wait),
    .ram_addr      (ram_addr),
    .ram_rd        (ram_rd),
    .ram_dout      (ram_dout),
    .core_busy     (core_busy),
    .cpu_we        (cpu_we),
    .nvram_dirty   (nvram_dirty),
    .upload_active (upload_active)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Behavioural CMOS: data appears RAM_LAT cycles after ram_rd, junk otherwise
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] pipe [RAM_LAT];
  always @(posedge clk_sys) begin
    if (ram_rd) pipe[0] <= mem[ram_addr];
    else        pipe[0] <= DATA_W'($urandom);
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[RAM_LAT-1];

  int         n_tests = 0;
  int         n_fail  = 0;
  // Reference state
  logic       dirty_m;
  logic [7:0] last_din;
  int         reads_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One matched read; bv bit i is core_busy in cycle i+1 after the request
  task automatic do_read(input logic [24:0] addr, input logic [15:0] bv);
    int         b;
    int         rd_cyc, din_cyc, low_cyc;
    bit         inr;
    logic [7:0] exp_din;
    inr     = (addr < 25'(DEPTH));
    b       = 0;
    for (int i = 0; i < 16 && bv[i]; i++) b++;
    exp_din = inr ? 8'(mem[addr[ADDR_W-1:0]]) : 8'hFF;
    rd_cyc  = 1 + b;
    din_cyc = inr ? (2 + b + RAM_LAT) : 1;
    low_cyc = din_cyc + 1;
    step();
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    core_busy  = 1'($urandom);
    @(negedge clk_sys);
    check("wait_req", ioctl_wait, 1);
    check("rd_req",   ram_rd,     0);
    for (int cyc = 1; cyc <= low_cyc; cyc++) begin
      step();
      ioctl_rd  = 1'b0;
      core_busy = (cyc <= 16) ? bv[cyc-1] : 1'b0;
      @(negedge clk_sys);
      check("rd_busy", ram_rd & core_busy, 0);
      check("ram_rd", ram_rd, inr && (cyc == rd_cyc));
      if (inr && cyc == rd_cyc) check("ram_addr", ram_addr, addr[ADDR_W-1:0]);
      if (cyc >= din_cyc) check("din", ioctl_din, exp_din);
      check("wait", ioctl_wait, cyc < low_cyc);
    end
    core_busy = 1'b0;
    last_din  = exp_din;
    reads_done++;
  endtask

  // A read that must be ignored entirely
  task automatic ignored_read(input logic up, input logic [15:0] idx);
    step();
    ioctl_upload = up;
    ioctl_index  = idx;
    ioctl_addr   = 25'($urandom_range(0, DEPTH - 1));
    ioctl_rd     = 1'b1;
    @(negedge clk_sys);
    check("ign_wait0", ioctl_wait, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      ioctl_rd = 1'b0;
      @(negedge clk_sys);
      check("ign_rd",   ram_rd,     0);
      check("ign_wait", ioctl_wait, 0);
      check("ign_din",  ioctl_din,  last_din);
    end
    ioctl_upload = 1'b0;
    ioctl_index  = 16'd4;
  endtask

  task automatic up_start();
    step();
    ioctl_upload = 1'b1;
    ioctl_index  = 16'd4;
    reads_done   = 0;
  endtask

  task automatic up_end(input logic we);
    step();
    ioctl_upload = 1'b0;
    cpu_we       = we;
    if (we)                  dirty_m = 1'b1;
    else if (reads_done > 0) dirty_m = 1'b0;
    step();
    cpu_we = 1'b0;
    @(negedge clk_sys);
    check("dirty_end", nvram_dirty,   dirty_m);
    check("upl_end",   upload_active, 0);
  endtask

  task automatic we_pulse();
    step();
    cpu_we = 1'b1;
    step();
    cpu_we  = 1'b0;
    dirty_m = 1'b1;
    @(negedge clk_sys);
    check("dirty_set", nvram_dirty, dirty_m);
  endtask

  task automatic full_upload(input logic we_at_end);
    up_start();
    for (int a = 0; a < DEPTH; a++)
      do_read(25'(a), 16'($urandom & $urandom & $urandom));
    up_end(we_at_end);
  endtask

  logic [24:0] ra;
  logic [9:0]  abort_a;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    mem[10'h123] = 4'hA;
    dirty_m      = 1'b0;
    last_din     = 8'h00;
    reads_done   = 0;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 16'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    core_busy    = 1'b0;
    cpu_we       = 1'b0;

    // Reset with random inputs: every output stays 0
    for (int c = 0; c < 6; c++) begin
      step();
      ioctl_upload = 1'($urandom);
      ioctl_index  = 16'($urandom_range(3, 5));
      ioctl_rd     = 1'($urandom);
      ioctl_addr   = 25'($urandom_range(0, 2047));
      core_busy    = 1'($urandom);
      cpu_we       = 1'($urandom);
      @(negedge clk_sys);
      check("rst_outs", {ioctl_din, ioctl_wait, ram_addr, ram_rd, nvram_dirty, upload_active}, 0);
    end
    step();
    ioctl_upload = 1'b0;
    ioctl_index  = 16'd4;
    ioctl_rd     = 1'b0;
    core_busy    = 1'b0;
    cpu_we       = 1'b0;
    reset_n      = 1'b1;
    @(negedge clk_sys);
    check("post_rst_wait",  ioctl_wait,  0);
    check("post_rst_dirty", nvram_dirty, 0);

    // Dirty set, then reads: plain, contended, out of range, randomized
    we_pulse();
    up_start();
    do_read(25'h123, 16'h0000);
    @(negedge clk_sys);
    check("upl_active", upload_active, 1);
    do_read(25'h123, 16'h001F);
    do_read(25'h400, 16'h0000);
    do_read(25'h1000123, 16'h0003);
    for (int k = 0; k < 60; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 25'($urandom) : 25'($urandom_range(0, DEPTH - 1));
      do_read(ra, 16'($urandom & $urandom));
    end
    up_end(1'b0);

    // Filtering: wrong index, no upload
    ignored_read(1'b1, 16'd0);
    ignored_read(1'b0, 16'd4);

    // Abort in LAT on an upload with no completed read: dirty survives
    we_pulse();
    up_start();
    abort_a      = 10'($urandom_range(0, DEPTH - 1));
    mem[abort_a] = ~last_din[DATA_W-1:0];
    step();
    ioctl_addr = {15'd0, abort_a};
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd   = 1'b0;
    core_busy  = 1'b0;
    step();
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_wait_hi", ioctl_wait, 1);
    step();
    @(negedge clk_sys);
    check("abort_wait_lo", ioctl_wait,  0);
    check("abort_din",     ioctl_din,   last_din);
    check("abort_dirty",   nvram_dirty, dirty_m);
    step();
    @(negedge clk_sys);
    check("abort_din2", ioctl_din, last_din);
    check("abort_idle", ioctl_wait, 0);

    // Full uploads: fall with cpu_we keeps dirty, clean fall clears it
    full_upload(1'b1);
    full_upload(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cmos_nvram_uploader
`default_nettype wire
